axi_line_master: RTL and testbench



---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_line_master.sv | 172 +++++++++++++++++
 tb/tb_axi_line_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the line-master FSM state type.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StAw,
        StW,
        StB,
        StDone
    } axi_line_state_e;

endpackage

// File: rtl/axi_line_master.sv
// AXI4 burst initiator: moves one whole cache line per request as a single INCR burst.
// One transaction outstanding; a single line register serves as both write source and read sink.
module axi_line_master
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned AXI_ID = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [ADDR_W-1:0]         req_addr_i,
    input  logic [DATA_W*BEATS-1:0]   req_wdata_i,

    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [DATA_W*BEATS-1:0]   resp_rdata_o,
    output logic                      resp_err_o,

    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [ID_W-1:0]           m_axi_awid,
    output logic [7:0]                m_axi_awlen,
    output logic [1:0]                m_axi_awburst,

    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic [DATA_W/8-1:0]       m_axi_wstrb,
    output logic                      m_axi_wlast,

    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp,
    input  logic [ID_W-1:0]           m_axi_bid,

    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [ID_W-1:0]           m_axi_arid,
    output logic [7:0]                m_axi_arlen,
    output logic [1:0]                m_axi_arburst,

    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic [ID_W-1:0]           m_axi_rid,
    input  logic                      m_axi_rlast
);

    localparam int unsigned LINE_W  = DATA_W * BEATS;
    localparam int unsigned LINE_B  = LINE_W / 8;
    localparam int unsigned CNT_W   = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ID_W-1:0]   OWN_ID    = ID_W'(AXI_ID);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_B - 1);

    axi_line_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic              last_beat;

    assign last_beat = (cnt_q == LAST_BEAT);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; read termination follows the beat counter, never RLAST
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid_i)               state_d = req_we_i ? StAw : StAr;
            StAr:   if (m_axi_arready)             state_d = StR;
            StR:    if (m_axi_rvalid && last_beat) state_d = StDone;
            StAw:   if (m_axi_awready)             state_d = StW;
            StW:    if (m_axi_wready && last_beat) state_d = StB;
            StB:    if (m_axi_bvalid)              state_d = StDone;
            StDone: if (resp_ready_i)              state_d = StIdle;
            default:                               state_d = StIdle;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        req_ready_o   = (state_q == StIdle) && rst_n_i;
        resp_valid_o  = (state_q == StDone);
        m_axi_arvalid = (state_q == StAr);
        m_axi_rready  = (state_q == StR);
        m_axi_awvalid = (state_q == StAw);
        m_axi_wvalid  = (state_q == StW);
        m_axi_bready  = (state_q == StB);
        m_axi_wlast   = (state_q == StW) && last_beat;
        m_axi_wdata   = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (cnt_q == CNT_W'(i)) m_axi_wdata = line_q[i*DATA_W +: DATA_W];
        end
    end

    assign m_axi_wstrb   = '1;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_arid    = OWN_ID;
    assign m_axi_awid    = OWN_ID;
    assign resp_rdata_o  = line_q;
    assign resp_err_o    = err_q;

    // Datapath: request capture, beat counter, line buffer and sticky error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= '0;
            line_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q <= req_addr_i & ALIGN_MASK;
                        line_q <= req_wdata_i;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                    end
                end
                StR: begin
                    if (m_axi_rvalid) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (cnt_q == CNT_W'(i)) line_q[i*DATA_W +: DATA_W] <= m_axi_rdata;
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                        if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rid != OWN_ID) ||
                            (m_axi_rlast != last_beat)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StW: begin
                    // Counter wraps to zero after the last beat since BEATS is a power of two
                    if (m_axi_wready) cnt_q <= cnt_q + CNT_W'(1);
                end
                StB: begin
                    if (m_axi_bvalid &&
                        ((m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != OWN_ID))) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master with an inline AXI responder and expectation queues.
module tb_axi_line_master;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         resp_valid, resp_ready = 1'b0, resp_err;
    logic [127:0] resp_rdata;
    logic         awvalid, awready = 1'b0;
    logic [31:0]  awaddr;
    logic [3:0]   awid;
    logic [7:0]   awlen;
    logic [1:0]   awburst;
    logic         wvalid, wready = 1'b0, wlast;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid = 1'b0, bready;
    logic [1:0]   bresp = '0;
    logic [3:0]   bid = '0;
    logic         arvalid, arready = 1'b0;
    logic [31:0]  araddr;
    logic [3:0]   arid;
    logic [7:0]   arlen;
    logic [1:0]   arburst;
    logic         rvalid = 1'b0, rready, rlast = 1'b0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic [3:0]   rid = '0;

    int total = 0;
    int bad   = 0;

    logic [127:0] rd_q[$];
    logic         err_q[$];
    logic [31:0]  addr_q[$];
    logic [31:0]  wbeat_q[$];

    axi_line_master dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awburst(awburst),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp), .m_axi_bid(bid),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_arid(arid), .m_axi_arlen(arlen), .m_axi_arburst(arburst),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
        .m_axi_rresp(rresp), .m_axi_rid(rid), .m_axi_rlast(rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a request; it is accepted at the next rising edge
    task automatic send_req(input logic we, input logic [31:0] addr, input logic [127:0] line,
                            input logic [127:0] exp_rdata, input logic exp_err);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = line;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) chk("req_accept_timeout", 1'b0, 1'b1);
        addr_q.push_back(addr & 32'hFFFF_FFF0);
        if (!we) rd_q.push_back(exp_rdata);
        else for (int i = 0; i < 4; i++) wbeat_q.push_back(line[i*32 +: 32]);
        err_q.push_back(exp_err);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_ar();
        int n;
        logic [31:0] a;
        n = 0;
        while (!arvalid && n < 50) begin tick(); n++; end
        if (!arvalid) chk("ar_timeout", 1'b0, 1'b1);
        a = addr_q.pop_front();
        chk("araddr", araddr, a);
        chk("arlen", arlen, 8'd3);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 4'd0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic do_r(input logic [127:0] line, input int err_beat, input int last_pos);
        int n;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1;
            rdata  = line[i*32 +: 32];
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            rlast  = (i == last_pos);
            rid    = 4'd0;
            n = 0;
            while (!rready && n < 50) begin tick(); n++; end
            if (!rready) chk("r_timeout", 1'b0, 1'b1);
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        chk("r_done_latency", resp_valid, 1'b1);
    endtask

    task automatic do_write(input logic stall, input logic [1:0] br, input logic [3:0] bi);
        int n, beat;
        logic hs;
        logic [31:0] a, eb;
        n = 0;
        while (!awvalid && n < 50) begin tick(); n++; end
        if (!awvalid) chk("aw_timeout", 1'b0, 1'b1);
        a = addr_q.pop_front();
        chk("awaddr", awaddr, a);
        chk("awlen", awlen, 8'd3);
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, 4'd0);
        hs = 1'b0; n = 0;
        while (!hs && n < 200) begin
            awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = awvalid && awready;
            tick(); n++;
        end
        awready = 1'b0;
        if (!hs) chk("aw_hs_timeout", 1'b0, 1'b1);
        chk("w_start", wvalid, 1'b1);
        beat = 0; n = 0;
        while (beat < 4 && n < 400) begin
            wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wvalid && wready) begin
                eb = wbeat_q.pop_front();
                chk("wdata", wdata, eb);
                chk("wlast", wlast, (beat == 3));
                chk("wstrb", wstrb, 4'hF);
                beat++;
            end
            tick(); n++;
        end
        wready = 1'b0;
        if (beat < 4) chk("w_timeout", 1'b0, 1'b1);
        chk("b_ready", bready, 1'b1);
        bvalid = 1'b1; bresp = br; bid = bi;
        tick();
        bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
    endtask

    // Check the completion, optionally stall resp_ready, then hand it off
    task automatic check_resp(input logic is_read, input int hold);
        int n;
        logic [127:0] er;
        logic ee;
        n = 0;
        while (!resp_valid && n < 50) begin tick(); n++; end
        if (!resp_valid) chk("resp_timeout", 1'b0, 1'b1);
        ee = err_q.pop_front();
        er = is_read ? rd_q.pop_front() : '0;
        if (is_read) chk("resp_rdata", resp_rdata, er);
        chk("resp_err", resp_err, ee);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", resp_valid, 1'b1);
            chk("hold_req_ready", req_ready, 1'b0);
            if (is_read) chk("hold_rdata", resp_rdata, er);
            chk("hold_err", resp_err, ee);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("idle_after_resp", req_ready, 1'b1);
        chk("resp_dropped", resp_valid, 1'b0);
    endtask

    localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE_W = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] LINE_C = 128'h0BADF00D_CAFEBABE_12345678_DEADBEEF;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 128'h0);
        chk("rst_err", resp_err, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_req_ready", req_ready, 1'b1);

        // Plain read, ready always high
        send_req(1'b0, 32'h0000_1234, '0, LINE_A, 1'b0);
        chk("ar_latency", arvalid, 1'b1);
        do_ar();
        do_r(LINE_A, -1, 3);
        check_resp(1'b1, 0);

        // Write with random AW/W stalls
        send_req(1'b1, 32'h0000_0040, LINE_W, '0, 1'b0);
        do_write(1'b1, 2'b00, 4'd0);
        check_resp(1'b0, 0);

        // SLVERR on beat 2
        send_req(1'b0, 32'h0000_2000, '0, LINE_C, 1'b1);
        do_ar();
        do_r(LINE_C, 2, 3);
        check_resp(1'b1, 0);

        // Early RLAST on beat 1: still four beats
        send_req(1'b0, 32'h0000_3018, '0, LINE_A, 1'b1);
        do_ar();
        do_r(LINE_A, -1, 1);
        check_resp(1'b1, 0);

        // Wrong BID on a write
        send_req(1'b1, 32'h0000_0080, LINE_C, '0, 1'b1);
        do_write(1'b0, 2'b00, 4'd5);
        check_resp(1'b0, 0);

        // resp_ready held low, then back-to-back read
        send_req(1'b0, 32'h0000_4000, '0, LINE_C, 1'b0);
        do_ar();
        do_r(LINE_C, -1, 3);
        check_resp(1'b1, 10);
        send_req(1'b0, 32'h0000_5004, '0, LINE_W, 1'b0);
        chk("b2b_arvalid", arvalid, 1'b1);
        do_ar();
        do_r(LINE_W, -1, 3);
        check_resp(1'b1, 0);

        // Reset during beat 1 of a write
        send_req(1'b1, 32'h0000_6000, LINE_A, '0, 1'b0);
        begin
            int n;
            logic [31:0] a, eb;
            n = 0;
            while (!awvalid && n < 50) begin tick(); n++; end
            a = addr_q.pop_front();
            chk("rst_case_awaddr", awaddr, a);
            awready = 1'b1; tick(); awready = 1'b0;
            wready = 1'b1;
            eb = wbeat_q.pop_front();
            chk("rst_case_wdata0", wdata, eb);
            tick();
            wready = 1'b0;
            chk("rst_case_beat1_valid", wvalid, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_wvalid", wvalid, 1'b0);
        chk("abort_awvalid", awvalid, 1'b0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        wbeat_q.delete(); err_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("abort_req_ready", req_ready, 1'b1);
        send_req(1'b0, 32'h0000_7000, '0, LINE_C, 1'b0);
        do_ar();
        do_r(LINE_C, -1, 3);
        check_resp(1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
